// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder_if
//   Bundles the seven-segment scan bus sampled by seg_scan_decoder and the
//   decoded snapshot it publishes.
//
//   Signals
//     an_i      anode lines, active-low, bit i = digit i
//     seg_i     cathodes, active-low, bit0 = CA(a) ... bit6 = CG(g)
//     digits_o  published digit values, nibble i = digit i
//     blank_o   published: digit i had no segment lit
//     err_o     published: digit i pattern was undecodable
//     frame_o   one-cycle strobe, a new snapshot is on the outputs
//     stale_o   scan stopped or incomplete
//
//   Modports
//     master  display side: drives the scan lines, observes the snapshot
//     slave   decoder side: samples the scan lines, drives the snapshot
// ---------------------------------------------------------------------------
interface seg_scan_decoder_if #(
    parameter int DIGITS = 7
);
    logic [DIGITS-1:0]   an_i;
    logic [6:0]          seg_i;
    logic [4*DIGITS-1:0] digits_o;
    logic [DIGITS-1:0]   blank_o;
    logic [DIGITS-1:0]   err_o;
    logic                frame_o;
    logic                stale_o;

    modport master (
        output an_i, seg_i,
        input  digits_o, blank_o, err_o, frame_o, stale_o
    );

    modport slave (
        input  an_i, seg_i,
        output digits_o, blank_o, err_o, frame_o, stale_o
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Passive receiver for a multiplexed, active-low seven-segment scan bus.
//   Synchronizes the anode/cathode lines, waits until one digit has been
//   shown unchanged for SETTLE samples, decodes it into a pending slot and,
//   once every position has been captured, publishes all slots together.
//
//   Ports
//     clk      system clock
//     rstn     asynchronous active-low reset
//     bus      seg_scan_decoder_if.slave (scan lines in, snapshot out)
//     state_o  debug view of the capture FSM (0 WAIT, 1 SETTLE, 2 HELD)
//
//   Output handshake: frame_o is a valid-only strobe. It is high for exactly
//   one cycle when digits_o/blank_o/err_o change to a new snapshot; there is
//   no ready and no backpressure, and the snapshot stays put until the next
//   frame_o.
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int DIGITS  = 7,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rstn,
    seg_scan_decoder_if.slave    bus,
    output logic [1:0]           state_o
);
    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // Synchronizers reset to all ones: no anode driven, nothing lit.
    logic [DIGITS-1:0] an_s1, an_s;
    logic [6:0]        seg_s1, seg_s;

    state_t              state, state_d;
    logic [DIGITS+6:0]   lat, lat_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                capture;

    logic [DIGITS-1:0]   an_low;
    logic                an_valid;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS+6:0]   sample;

    logic [5:0]          dec;
    logic [DIGITS-1:0]   mask, mask_d;
    logic [IDLE_W-1:0]   idle, idle_d;
    logic                publish;
    logic                timeout_hit;

    logic [3:0]          pend_val   [DIGITS];
    logic                pend_blank [DIGITS];
    logic                pend_err   [DIGITS];

    // Returns {err, blank, value} for an active-low cathode pattern.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [6:0] lit;
        lit = ~seg;
        case (lit)
            7'h00:   decode = {1'b0, 1'b1, 4'h0};
            7'h3F:   decode = {1'b0, 1'b0, 4'h0};
            7'h06:   decode = {1'b0, 1'b0, 4'h1};
            7'h5B:   decode = {1'b0, 1'b0, 4'h2};
            7'h4F:   decode = {1'b0, 1'b0, 4'h3};
            7'h66:   decode = {1'b0, 1'b0, 4'h4};
            7'h6D:   decode = {1'b0, 1'b0, 4'h5};
            7'h7D:   decode = {1'b0, 1'b0, 4'h6};
            7'h07:   decode = {1'b0, 1'b0, 4'h7};
            7'h7F:   decode = {1'b0, 1'b0, 4'h8};
            7'h6F:   decode = {1'b0, 1'b0, 4'h9};
            default: decode = {1'b1, 1'b0, 4'hF};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_s1  <= '1;
            an_s   <= '1;
            seg_s1 <= '1;
            seg_s  <= '1;
        end else begin
            an_s1  <= bus.an_i;
            an_s   <= an_s1;
            seg_s1 <= bus.seg_i;
            seg_s  <= seg_s1;
        end
    end

    // A sample is usable only when exactly one anode is pulled low; overlap
    // during anode transitions shows up as two low bits and is rejected.
    always_comb begin
        an_low   = ~an_s;
        an_valid = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        idx      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) idx = IDX_W'(i);
        end
        sample = {an_s, seg_s};
        dec    = decode(seg_s);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_WAIT;
            lat   <= '1;
            cnt   <= '0;
        end else begin
            state <= state_d;
            lat   <= lat_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        lat_d   = lat;
        cnt_d   = cnt;
        capture = 1'b0;
        case (state)
            ST_WAIT: begin
                if (an_valid) begin
                    lat_d   = sample;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!an_valid) begin
                    state_d = ST_WAIT;
                end else if (sample != lat) begin
                    lat_d = sample;
                    cnt_d = CNT_W'(1);
                end else if (cnt == CNT_W'(SETTLE - 1)) begin
                    // This sample is the SETTLE-th identical one.
                    cnt_d   = CNT_W'(SETTLE);
                    capture = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!an_valid) begin
                    state_d = ST_WAIT;
                end else if (sample != lat) begin
                    lat_d   = sample;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign state_o = state;

    // A capture landing on the publish cycle sets its bit after the clear,
    // so it counts toward the following frame. The frame_o guard keeps the
    // strobe from ever being high two cycles running.
    always_comb begin
        publish     = (&mask) && !bus.frame_o;
        idle_d      = capture ? '0
                    : (idle == IDLE_W'(TIMEOUT)) ? idle
                    : idle + IDLE_W'(1);
        timeout_hit = (idle_d == IDLE_W'(TIMEOUT));
        mask_d      = mask;
        if (publish || timeout_hit) mask_d = '0;
        if (capture) mask_d[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask         <= '0;
            idle         <= '0;
            bus.digits_o <= '0;
            bus.blank_o  <= '0;
            bus.err_o    <= '0;
            bus.frame_o  <= 1'b0;
            bus.stale_o  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                pend_val[i]   <= 4'h0;
                pend_blank[i] <= 1'b0;
                pend_err[i]   <= 1'b0;
            end
        end else begin
            mask        <= mask_d;
            idle        <= idle_d;
            bus.frame_o <= publish;
            if (capture) begin
                pend_val[idx]   <= dec[3:0];
                pend_blank[idx] <= dec[4];
                pend_err[idx]   <= dec[5];
            end
            if (publish) begin
                for (int i = 0; i < DIGITS; i++) begin
                    bus.digits_o[4*i +: 4] <= pend_val[i];
                    bus.blank_o[i]         <= pend_blank[i];
                    bus.err_o[i]           <= pend_err[i];
                end
                bus.stale_o <= 1'b0;
            end else if (timeout_hit) begin
                bus.stale_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder (DIGITS=7, SETTLE=4, TIMEOUT=100).
//   Stimulus pushes the expected snapshot of each scan into exp_q; the
//   monitor pops and compares whenever frame_o is seen.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;
    localparam int DIGITS  = 7;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;
    localparam int W       = 4*DIGITS + 2*DIGITS;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] state_o;

    seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_decoder #(
        .DIGITS (DIGITS),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];   // expected frame cycle, -1 = don't care
    int           exp_stl_q[$];   // 1 = stale_o must have been high just before
    int           checks    = 0;
    int           passes    = 0;
    int           frame_cnt = 0;
    logic         prev_stale = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.frame_o === 1'b1) begin
                frame_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: frame_o=1 at cycle %0d, expected no frame", cyc);
                end else begin
                    logic [W-1:0] e;
                    int           c;
                    int           s;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    s = exp_stl_q.pop_front();
                    check("frame_data", {bus.digits_o, bus.blank_o, bus.err_o}, e);
                    if (c >= 0) check("frame_latency", cyc, c);
                    check("stale_at_frame", bus.stale_o, 0);
                    if (s == 1) check("stale_before_frame", prev_stale, 1);
                end
            end
            prev_stale = bus.stale_o;
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: seg_of = 7'h40;
            1: seg_of = 7'h79;
            2: seg_of = 7'h24;
            3: seg_of = 7'h30;
            4: seg_of = 7'h19;
            5: seg_of = 7'h12;
            6: seg_of = 7'h02;
            7: seg_of = 7'h78;
            8: seg_of = 7'h00;
            default: seg_of = 7'h10;
        endcase
    endfunction

    function automatic logic [DIGITS-1:0] an_of(input int i);
        logic [DIGITS-1:0] one;
        one   = DIGITS'(1);
        an_of = ~(one << i);
    endfunction

    // Called at a negedge; holds the pattern for n cycles.
    task automatic drive(input logic [DIGITS-1:0] an, input logic [6:0] seg, input int n);
        bus.an_i  = an;
        bus.seg_i = seg;
        repeat (n) @(negedge clk);
    endtask

    // One full scan, digits 0..DIGITS-1, 20 cycles each.
    task automatic scan(input logic [6:0] segs[DIGITS], input bit chk_lat);
        for (int i = 0; i < DIGITS; i++) begin
            if (i == DIGITS - 1) exp_cyc_q.push_back(chk_lat ? cyc + 2 + SETTLE + 1 : -1);
            drive(an_of(i), segs[i], 20);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] segs[DIGITS];
        int         f0;
        int         t;

        bus.an_i  = '1;
        bus.seg_i = '1;
        rstn      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        check("rst_digits", bus.digits_o, 0);
        check("rst_blank",  bus.blank_o,  0);
        check("rst_err",    bus.err_o,    0);
        check("rst_frame",  bus.frame_o,  0);
        check("rst_stale",  bus.stale_o,  0);
        check("rst_state",  state_o,      0);

        repeat (10) @(negedge clk);
        check("idle_frames", frame_cnt, 0);
        check("idle_stale",  bus.stale_o, 0);

        // Clean scan: digit i shows i+1.
        for (int i = 0; i < DIGITS; i++) segs[i] = seg_of(i + 1);
        f0 = frame_cnt;
        exp_q.push_back({28'h7654321, 7'h00, 7'h00});
        exp_stl_q.push_back(0);
        scan(segs, 1'b1);
        check("clean_frames", frame_cnt - f0, 1);

        // Ghosting: anode overlap, then the new anode with the old segments.
        f0 = frame_cnt;
        exp_q.push_back({28'h7654321, 7'h00, 7'h00});
        exp_stl_q.push_back(0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i > 0) begin
                drive(an_of(i) & an_of(i - 1), seg_of(i + 1), 2);
                drive(an_of(i), seg_of(i), 2);
            end
            if (i == DIGITS - 1) exp_cyc_q.push_back(-1);
            drive(an_of(i), seg_of(i + 1), 20);
        end
        check("ghost_frames", frame_cnt - f0, 1);

        // Blank digit 3, segment 'a' only on digit 5.
        for (int i = 0; i < DIGITS; i++) segs[i] = seg_of(i + 1);
        segs[3] = 7'h7F;
        segs[5] = 7'h7E;
        f0 = frame_cnt;
        exp_q.push_back({28'h7F50321, 7'b0001000, 7'b0100000});
        exp_stl_q.push_back(0);
        scan(segs, 1'b0);
        check("blank_err_frames", frame_cnt - f0, 1);

        // Overwrite: digits 0..5, digit 2 again as 9, then digit 6.
        f0 = frame_cnt;
        exp_q.push_back({28'h7654921, 7'h00, 7'h00});
        exp_stl_q.push_back(0);
        for (int i = 0; i < 6; i++) drive(an_of(i), seg_of(i + 1), 20);
        drive(an_of(2), seg_of(9), 20);
        check("overwrite_no_early_frame", frame_cnt - f0, 0);
        exp_cyc_q.push_back(cyc + 2 + SETTLE + 1);
        drive(an_of(6), seg_of(7), 20);
        check("overwrite_frames", frame_cnt - f0, 1);

        // Stale: partial scan, then the display goes dark.
        f0 = frame_cnt;
        for (int i = 0; i < 3; i++) drive(an_of(i), seg_of(8), 20);
        t = cyc;
        drive(an_of(3), seg_of(8), 20);
        bus.an_i = '1;
        // Capture of digit 3 lands 2+SETTLE edges after t.
        while (cyc < t + 2 + SETTLE + TIMEOUT - 1) @(negedge clk);
        check("stale_not_yet", bus.stale_o, 0);
        @(negedge clk);
        check("stale_raised", bus.stale_o, 1);
        check("stale_digits_kept", bus.digits_o, 28'h7654921);
        check("stale_no_frame", frame_cnt - f0, 0);
        repeat (5) @(negedge clk);

        // Resume: digit i shows 9-i; full frame required after the mask clear.
        for (int i = 0; i < DIGITS; i++) segs[i] = seg_of(9 - i);
        exp_q.push_back({28'h3456789, 7'h00, 7'h00});
        exp_stl_q.push_back(1);
        scan(segs, 1'b1);
        check("resume_frames", frame_cnt - f0, 1);
        check("resume_stale", bus.stale_o, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
